// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core encodings: MDU operation codes and latency defaults
package mips_pkg;

  typedef enum logic [2:0] {
    MDU_DIV   = 3'b000,
    MDU_DIVU  = 3'b001,
    MDU_MULT  = 3'b010,
    MDU_MULTU = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - EX-stage multiply/divide unit owning HI/LO, multi-cycle MULT/DIV with Busy
module mdu
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] p_hi, p_lo;
  logic        p_skip;
  logic        accept, commit, mt_hi, mt_lo;

  logic [63:0] prod_s, prod_u;
  logic        div_ovf, div_zero;
  logic [31:0] b_safe, quot_s, rem_s, quot_u, rem_u;
  logic [31:0] res_hi, res_lo;
  logic        res_skip;

  always_comb begin
    prod_u   = {32'b0, A} * {32'b0, B};
    prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    div_zero = (B == 32'd0);
    div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    // Divisor forced to 1 when the real result is special-cased, so the divider never traps
    b_safe   = (div_zero || div_ovf) ? 32'd1 : B;
    quot_s   = $signed(A) / $signed(b_safe);
    rem_s    = $signed(A) % $signed(b_safe);
    quot_u   = A / b_safe;
    rem_u    = A % b_safe;
  end

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_skip = 1'b0;
    case (MDUOp)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        res_skip = div_zero;
        res_lo   = div_ovf ? 32'h8000_0000 : quot_s;
        res_hi   = div_ovf ? 32'd0 : rem_s;
      end
      MDU_DIVU: begin
        res_skip = div_zero;
        res_lo   = quot_u;
        res_hi   = rem_u;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (is_muldiv(MDUOp)) begin
            accept    = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = is_mult(MDUOp) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          end
          mt_hi = (MDUOp == MDU_MTHI);
          mt_lo = (MDUOp == MDU_MTLO);
        end
      end
      RUN: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      p_skip <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        p_hi   <= res_hi;
        p_lo   <= res_lo;
        p_skip <= res_skip;
      end
      if (commit && !p_skip) begin
        HI <= p_hi;
        LO <= p_lo;
      end
      if (mt_hi) HI <= A;
      if (mt_lo) LO <= A;
    end
  end

  assign Busy = (state == RUN);
  assign Out  = HiSel ? HI : LO;

endmodule
